// File: rtl/ser_frame_pkg.sv
// rtl/ser_frame_pkg.sv - shared FSM encoding and line levels for ser_frame_rx (SER_FRAME_RX_PARITY_EN adds PAR)
package ser_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
`ifdef SER_FRAME_RX_PARITY_EN
    PAR  = 2'd2,
`endif
    STOP = 2'd3
  } state_t;

  localparam logic LVL_IDLE  = 1'b0;
  localparam logic LVL_START = 1'b1;
  localparam logic LVL_STOP  = 1'b0;

endpackage

// File: rtl/ser_frame_rx_if.sv
// rtl/ser_frame_rx_if.sv - receiver output handshake and status pulses
interface ser_frame_rx_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] Q;
  logic             V;
  logic             A;
  logic             E;
  logic             O;

  // receiver side drives the word and status, consumer drives accept
  modport master (output Q, output V, output E, output O, input A);
  modport slave  (input Q, input V, input E, input O, output A);

endinterface

// File: rtl/ser_frame_hold.sv
// rtl/ser_frame_hold.sv - one-entry output holding register with overrun detection
module ser_frame_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             a,
  output logic [WIDTH-1:0] q,
  output logic             v,
  output logic             o
);

  // a completed word is taken when the slot is free or being drained this cycle, else dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      v <= 1'b0;
      o <= 1'b0;
    end else begin
      o <= 1'b0;
      if (load) begin
        if (!v || a) begin
          q <= word;
          v <= 1'b1;
        end else begin
          o <= 1'b1;
        end
      end else if (v && a) begin
        v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ser_frame_rx.sv
// rtl/ser_frame_rx.sv - serial frame receiver, optional even parity via SER_FRAME_RX_PARITY_EN
module ser_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic C,
  input  logic R,
  input  logic D,
  ser_frame_rx_if.master bus
);

  import ser_frame_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             frame_ok, frame_ok_n;
  logic             err, err_n;
  logic             stop_ok;
`ifdef SER_FRAME_RX_PARITY_EN
  logic             perr, perr_n;
`endif

  // state and datapath registers; reset wins over any frame in progress
  always_ff @(posedge C) begin
    if (R) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      frame_ok <= 1'b0;
      err      <= 1'b0;
`ifdef SER_FRAME_RX_PARITY_EN
      perr     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      frame_ok <= frame_ok_n;
      err      <= err_n;
`ifdef SER_FRAME_RX_PARITY_EN
      perr     <= perr_n;
`endif
    end
  end

  // next-state, LSB-first shifting and end-of-frame verdict
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    frame_ok_n = 1'b0;
    err_n      = 1'b0;
    stop_ok    = (D == LVL_STOP);
`ifdef SER_FRAME_RX_PARITY_EN
    perr_n     = perr;
    stop_ok    = (D == LVL_STOP) && !perr;
`endif
    case (state)
      IDLE: begin
        if (D == LVL_START) begin
          state_n = DATA;
          cnt_n   = '0;
        end
      end
      DATA: begin
        shreg_n = {D, shreg[WIDTH-1:1]};
        cnt_n   = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
`ifdef SER_FRAME_RX_PARITY_EN
          state_n = PAR;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef SER_FRAME_RX_PARITY_EN
      PAR: begin
        perr_n  = ^{shreg, D};
        state_n = STOP;
      end
`endif
      STOP: begin
        state_n = IDLE;
        if (stop_ok) begin
          frame_ok_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.E = err;

  ser_frame_hold #(.WIDTH(WIDTH)) u_hold (
    .clk  (C),
    .rst  (R),
    .load (frame_ok),
    .word (shreg),
    .a    (bus.A),
    .q    (bus.Q),
    .v    (bus.V),
    .o    (bus.O)
  );

endmodule

// File: tb/tb_ser_frame_rx.sv
// tb/tb_ser_frame_rx.sv - scoreboard bench for ser_frame_rx
module tb_ser_frame_rx;

  import ser_frame_pkg::*;

  localparam int WIDTH = 8;
`ifdef SER_FRAME_RX_PARITY_EN
  localparam int FLEN = WIDTH + 3;
`else
  localparam int FLEN = WIDTH + 2;
`endif

  logic C = 1'b0;
  logic R;
  logic D;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int e_cnt   = 0;
  int o_cnt   = 0;
  int exp_e   = 0;
  int exp_o   = 0;
  logic [WIDTH-1:0] exp_q[$];

  ser_frame_rx_if #(.WIDTH(WIDTH)) bus ();

  ser_frame_rx #(.WIDTH(WIDTH)) dut (
    .C   (C),
    .R   (R),
    .D   (D),
    .bus (bus)
  );

  always #5 C = ~C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frame(input logic [WIDTH-1:0] w, input logic stop_lvl);
`ifdef SER_FRAME_RX_PARITY_EN
    return 32'({stop_lvl, ^w, w, 1'b1});
`else
    return 32'({stop_lvl, w, 1'b1});
`endif
  endfunction

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      D = bits[i];
      @(posedge C);
      #1;
    end
  endtask

  task automatic idle(input int n);
    D = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge C);
      #1;
    end
  endtask

  // monitor: every consumed word is checked against the scoreboard, pulses are counted
  always @(negedge C) begin
    if (!R) begin
      if (bus.V && bus.A) begin
        if (exp_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_word: got %0h expected none", bus.Q);
        end else begin
          chk("word", 32'(bus.Q), 32'(exp_q.pop_front()));
        end
      end
      if (bus.E) e_cnt++;
      if (bus.O) o_cnt++;
    end
  end

  initial begin
    R = 1'b1;
    D = 1'b0;
    bus.A = 1'b0;
    idle(2);
    chk("rst_Q", 32'(bus.Q), 0);
    chk("rst_V", 32'(bus.V), 0);
    chk("rst_E", 32'(bus.E), 0);
    chk("rst_O", 32'(bus.O), 0);
    R = 1'b0;
    idle(1);

    // single frame 0xA5, latency and one-cycle valid
    bus.A = 1'b1;
    exp_q.push_back(8'hA5);
    send_bits(frame(8'hA5, 1'b0), FLEN);
    chk("a5_V_at_stop", 32'(bus.V), 0);
    idle(1);
    chk("a5_V", 32'(bus.V), 1);
    chk("a5_Q", 32'(bus.Q), 32'h A5);
    chk("a5_E", 32'(bus.E), 0);
    chk("a5_O", 32'(bus.O), 0);
    idle(1);
    chk("a5_V_cleared", 32'(bus.V), 0);

    // framing error then normal frame
    send_bits(frame(8'h3C, 1'b1), FLEN);
    exp_e++;
    chk("fe_E", 32'(bus.E), 1);
    idle(1);
    chk("fe_E_end", 32'(bus.E), 0);
    chk("fe_V", 32'(bus.V), 0);
    exp_q.push_back(8'h11);
    send_bits(frame(8'h11, 1'b0), FLEN);
    idle(2);

    // overrun: 0x01 held, 0x02 dropped
    bus.A = 1'b0;
    exp_q.push_back(8'h01);
    send_bits(frame(8'h01, 1'b0), FLEN);
    idle(1);
    chk("ov_first_Q", 32'(bus.Q), 32'h01);
    send_bits(frame(8'h02, 1'b0), FLEN);
    idle(1);
    exp_o++;
    chk("ov_O", 32'(bus.O), 1);
    chk("ov_Q", 32'(bus.Q), 32'h01);
    chk("ov_V", 32'(bus.V), 1);
    idle(1);
    chk("ov_O_end", 32'(bus.O), 0);
    bus.A = 1'b1;
    idle(1);
    chk("ov_V_cleared", 32'(bus.V), 0);

    // accept and completion on the same edge
    bus.A = 1'b0;
    exp_q.push_back(8'h55);
    send_bits(frame(8'h55, 1'b0), FLEN);
    idle(1);
    chk("sim_Q55", 32'(bus.Q), 32'h55);
    send_bits(frame(8'h66, 1'b0), FLEN);
    bus.A = 1'b1;
    exp_q.push_back(8'h66);
    idle(1);
    chk("sim_Q", 32'(bus.Q), 32'h66);
    chk("sim_V", 32'(bus.V), 1);
    chk("sim_O", 32'(bus.O), 0);
    idle(1);
    chk("sim_V_cleared", 32'(bus.V), 0);

    // reset mid-frame while a word is held
    bus.A = 1'b0;
    send_bits(frame(8'h9A, 1'b0), FLEN);
    idle(1);
    chk("mr_V_held", 32'(bus.V), 1);
    send_bits(32'b0_1101, 5);
    R = 1'b1;
    D = 1'b0;
    @(posedge C);
    #1;
    chk("mr_Q", 32'(bus.Q), 0);
    chk("mr_V", 32'(bus.V), 0);
    chk("mr_E", 32'(bus.E), 0);
    chk("mr_O", 32'(bus.O), 0);
    chk("mr_state", 32'(dut.state), 32'(IDLE));
    R = 1'b0;
    bus.A = 1'b1;
    exp_q.push_back(8'hF0);
    send_bits(frame(8'hF0, 1'b0), FLEN);
    idle(2);

`ifdef SER_FRAME_RX_PARITY_EN
    // even parity good and bad
    exp_q.push_back(8'h07);
    send_bits(32'b0_1_00000111_1, 11);
    idle(1);
    chk("par_ok_V", 32'(bus.V), 1);
    idle(1);
    send_bits(32'b0_0_00000111_1, 11);
    exp_e++;
    chk("par_bad_E", 32'(bus.E), 1);
    idle(1);
    chk("par_bad_V", 32'(bus.V), 0);
    idle(1);
`endif

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("e_pulses", 32'(e_cnt), 32'(exp_e));
    chk("o_pulses", 32'(o_cnt), 32'(exp_o));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ser_frame_rx.md
SER_FRAME_RX -- requirements
Module: ser_frame_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of data bits per frame, legal range 2..16.
REQ-002 SHALL have port C, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port R, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port D, input, 1 bit: serial data from the upstream shift-register stage output (Q2), sampled once per rising edge of C.
REQ-005 SHALL have port A, input, 1 bit: consumer accept; a word is consumed on a rising edge of C where V=1 and A=1.
REQ-006 SHALL have port Q, output, WIDTH bits: received parallel word.
REQ-007 SHALL have port V, output, 1 bit: Q holds an unconsumed word.
REQ-008 SHALL have port E, output, 1 bit: one-cycle framing/parity error pulse.
REQ-009 SHALL have port O, output, 1 bit: one-cycle overrun pulse.

Function
REQ-010 SHALL use frame format: idle line 0; start bit 1; WIDTH data bits, LSB first; optional parity bit (REQ-024); stop bit 0.
REQ-011 SHALL implement FSM states IDLE, DATA, PAR, STOP.
REQ-012 SHALL go IDLE->DATA on D=1 sampled in IDLE; it SHALL stay in IDLE while D=0.
REQ-013 SHALL shift D into the data register in DATA on each edge; after the WIDTH-th bit it SHALL go to PAR if parity is compiled in, else to STOP.
REQ-014 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits, cleared on entry to DATA, with no wrap inside a frame.
REQ-015 SHALL treat D=0 sampled in STOP as a good frame; D=1 SHALL pulse E for one cycle and discard the frame.
REQ-016 SHALL always return from STOP to IDLE; back-to-back frames need at least one idle cycle after the stop bit.
REQ-017 SHALL, for a good frame with V=0, load Q and set V=1 on the edge after the stop bit is sampled (latency: stop-bit edge + 1).
REQ-018 SHALL hold Q and V stable while V=1 and A=0.
REQ-019 SHALL clear V on accept (V=1, A=1) when no good frame completes in the same cycle.
REQ-020 SHALL, on accept and good-frame completion in the same cycle, load the new word and keep V=1 without an O pulse.
REQ-021 SHALL, on good-frame completion while V=1 and A=0, drop the new word, keep the old Q, and pulse O for one cycle.
REQ-022 SHALL ignore A when V=0.

Reset
REQ-023 SHALL, when R=1 on an edge, set state IDLE, counter 0, data register 0, Q=0, V=0, E=0, O=0, regardless of frame in progress; R SHALL have priority over all other inputs, including a simultaneous A or stop bit.

Configuration
REQ-024 SHALL use macro SER_FRAME_RX_PARITY_EN: when defined, the PAR state samples one even-parity bit after the data bits (data XOR parity must equal 0) and a mismatch pulses E in the STOP cycle and discards the frame even if the stop bit is good; when undefined, the PAR state, its logic, and the parity bit do not exist, and the frame is WIDTH+2 bits.

Structure
REQ-025 SHALL define the FSM state encoding (2-bit typedef) and the idle/start/stop level constants (0/1/0) in shared package ser_frame_pkg.
REQ-026 SHALL place the one-entry output holding register (Q, V, A, overrun logic) in sub-module ser_frame_hold, instantiated once.

Verification
REQ-027 SHALL cover a single frame: WIDTH=8, parity off; D = 1, then bits of 0xA5 LSB first, then 0; A=1 -> Q=0xA5, V=1 for one cycle starting at stop-bit edge + 1; E=0 and O=0.
REQ-028 SHALL cover a framing error: frame for 0x3C with stop bit 1 -> E pulses once, V stays 0, and the receiver accepts a following frame for 0x11 normally.
REQ-029 SHALL cover an overrun: A=0, frames 0x01 then 0x02 -> Q=0x01, V=1, O pulses at the second completion; raising A then clears V.
REQ-030 SHALL cover simultaneous accept and completion: V=1 holding 0x55, A=1 on the completion edge of 0x66 -> Q=0x66, V stays 1, O=0.
REQ-031 SHALL cover reset mid-frame: R=1 after 4 data bits -> all outputs 0 and state IDLE next edge; a fresh frame 0xF0 is then received correctly.
REQ-032 SHALL cover parity with SER_FRAME_RX_PARITY_EN defined: 0x07 with parity bit 1 -> V=1; 0x07 with parity bit 0 -> E pulse and V=0.
